// File: rtl/predictor_pkg.sv
// Shared constants for the branch outcome predictor.
// PRED_MODE selects the rule that turns an entry's history into a prediction.
package predictor_pkg;

   localparam int unsigned PRED_MODE_REPLAY   = 0;
   localparam int unsigned PRED_MODE_MAJORITY = 1;

endpackage

// File: rtl/predictor_popcnt.sv
// Combinational population count of a WIDTH-bit vector.
// The count is full width, so it never truncates.
module predictor_popcnt #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] bits,
   output logic [CNT_W-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt = cnt + CNT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/predictor_nrec.sv
// Per-entry outcome history predictor: circular history, sticky full flag,
// and a registered one-cycle lookup that returns replay or majority prediction.
module predictor_nrec
   import predictor_pkg::*;
#(
   parameter int unsigned ENTRY_NUM = 256,
   parameter int unsigned ADDR_W    = $clog2(ENTRY_NUM),
   parameter int unsigned HIST_LEN  = 10,
   parameter int unsigned PRED_MODE = 0
) (
   input  logic              cpu_clk,
   input  logic              cpu_rstn,
   input  logic              predictor_ren,
   input  logic [ADDR_W-1:0] predictor_raddr,
   input  logic              predictor_wen,
   input  logic [ADDR_W-1:0] predictor_waddr,
   input  logic              branch_taken_ex,
   input  logic              predictor_flush,
   output logic              pred_entry_valid,
   output logic              predictor_rd_data,
   output logic              pred_rd_vld
);

   localparam int unsigned PTR_W = $clog2(HIST_LEN);
   localparam int unsigned CNT_W = $clog2(HIST_LEN + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(HIST_LEN - 1);

   logic [HIST_LEN-1:0] hist_q [ENTRY_NUM];
   logic [PTR_W-1:0]    ptr_q  [ENTRY_NUM];
   logic [ENTRY_NUM-1:0] full_q;

   logic [HIST_LEN-1:0] rd_hist;
   logic [PTR_W-1:0]    wr_ptr;
   logic                pred_bit;

   assign rd_hist = hist_q[predictor_raddr];
   assign wr_ptr  = ptr_q[predictor_waddr];

   generate
      if (PRED_MODE == PRED_MODE_MAJORITY) begin : g_majority
         localparam logic [CNT_W-1:0] HALF = CNT_W'(HIST_LEN / 2);
         logic [CNT_W-1:0] pop_cnt;

         predictor_popcnt #(
            .WIDTH (HIST_LEN),
            .CNT_W (CNT_W)
         ) u_popcnt (
            .bits (rd_hist),
            .cnt  (pop_cnt)
         );

         // Strictly greater than half, so a tie predicts not-taken.
         assign pred_bit = (pop_cnt > HALF);
      end else begin : g_replay
         logic [PTR_W-1:0] rd_ptr;

         // The slot the pointer names is the oldest record still held.
         assign rd_ptr   = ptr_q[predictor_raddr];
         assign pred_bit = rd_hist[rd_ptr];
      end
   endgenerate

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            hist_q[i] <= '0;
            ptr_q[i]  <= '0;
         end
         full_q <= '0;
      end else if (predictor_flush) begin
         for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            hist_q[i] <= '0;
            ptr_q[i]  <= '0;
         end
         full_q <= '0;
      end else if (predictor_wen) begin
         hist_q[predictor_waddr][wr_ptr] <= branch_taken_ex;
         ptr_q[predictor_waddr]          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (wr_ptr == PTR_LAST) begin
            full_q[predictor_waddr] <= 1'b1;
         end
      end
   end

   // Lookup reads the registered arrays, so a same-cycle write is not visible.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         pred_entry_valid  <= 1'b0;
         predictor_rd_data <= 1'b0;
         pred_rd_vld       <= 1'b0;
      end else if (predictor_flush) begin
         pred_entry_valid  <= 1'b0;
         predictor_rd_data <= 1'b0;
         pred_rd_vld       <= 1'b0;
      end else if (predictor_ren) begin
         pred_entry_valid  <= full_q[predictor_raddr];
         predictor_rd_data <= pred_bit;
         pred_rd_vld       <= 1'b1;
      end else begin
         pred_rd_vld       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_predictor_nrec.sv
// Scoreboard bench: replay and majority instances share stimulus; each read
// pushes hand-computed expectations that a negedge monitor pops on pred_rd_vld.
module tb_predictor_nrec;

   logic       cpu_clk;
   logic       cpu_rstn;
   logic       ren, wen, tk, fl;
   logic [3:0] raddr, waddr;
   logic       r_valid, r_data, r_vld;
   logic       m_valid, m_data, m_vld;

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic v;
      logic rd;
      logic md;
   } exp_t;

   exp_t q[$];

   predictor_nrec #(
      .ENTRY_NUM (16),
      .HIST_LEN  (4),
      .PRED_MODE (0)
   ) u_rep (
      .cpu_clk           (cpu_clk),
      .cpu_rstn          (cpu_rstn),
      .predictor_ren     (ren),
      .predictor_raddr   (raddr),
      .predictor_wen     (wen),
      .predictor_waddr   (waddr),
      .branch_taken_ex   (tk),
      .predictor_flush   (fl),
      .pred_entry_valid  (r_valid),
      .predictor_rd_data (r_data),
      .pred_rd_vld       (r_vld)
   );

   predictor_nrec #(
      .ENTRY_NUM (16),
      .HIST_LEN  (4),
      .PRED_MODE (1)
   ) u_maj (
      .cpu_clk           (cpu_clk),
      .cpu_rstn          (cpu_rstn),
      .predictor_ren     (ren),
      .predictor_raddr   (raddr),
      .predictor_wen     (wen),
      .predictor_waddr   (waddr),
      .branch_taken_ex   (tk),
      .predictor_flush   (fl),
      .pred_entry_valid  (m_valid),
      .predictor_rd_data (m_data),
      .pred_rd_vld       (m_vld)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(negedge cpu_clk) begin
      if (cpu_rstn && (r_vld || m_vld)) begin
         if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_rd: got vld rep=%0b maj=%0b expected no read", r_vld, m_vld);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("rep_rd", {5'd0, r_vld, r_valid, r_data}, {5'd0, 1'b1, e.v, e.rd});
            check("maj_rd", {5'd0, m_vld, m_valid, m_data}, {5'd0, 1'b1, e.v, e.md});
         end
      end
   end

   task automatic op(input logic i_ren, input logic [3:0] i_ra, input logic i_wen,
                     input logic [3:0] i_wa, input logic i_tk, input logic i_fl);
      ren = i_ren; raddr = i_ra; wen = i_wen; waddr = i_wa; tk = i_tk; fl = i_fl;
      @(posedge cpu_clk);
      #1;
      ren = 1'b0; wen = 1'b0; fl = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic t);
      op(1'b0, 4'd0, 1'b1, a, t, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a, input logic v, input logic rep_d, input logic maj_d);
      q.push_back('{v: v, rd: rep_d, md: maj_d});
      op(1'b1, a, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic outs(input string nm, input logic [2:0] exp);
      check({nm, "_rep"}, {5'd0, r_vld, r_valid, r_data}, {5'd0, exp});
      check({nm, "_maj"}, {5'd0, m_vld, m_valid, m_data}, {5'd0, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      cpu_rstn = 1'b0;
      ren = 1'b0; wen = 1'b0; tk = 1'b0; fl = 1'b0; raddr = '0; waddr = '0;
      repeat (3) @(posedge cpu_clk);
      #1;
      outs("reset", 3'b000);
      cpu_rstn = 1'b1;

      // Entry 5: T,N,T,T then further updates
      wr(5, 1); wr(5, 0); wr(5, 1); wr(5, 1);
      rd(5, 1, 1, 1);
      wr(5, 0);
      rd(5, 1, 0, 0);
      wr(5, 1);
      rd(5, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         op(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
         outs("hold", 3'b011);
      end

      // Entry 3: tie handling in majority mode
      wr(3, 1); wr(3, 1); wr(3, 0); wr(3, 0);
      rd(3, 1, 1, 0);
      wr(3, 1);
      rd(3, 1, 1, 0);
      wr(3, 1);
      rd(3, 1, 0, 0);
      wr(3, 1); wr(3, 1);
      rd(3, 1, 1, 1);

      // Entry 7: read sees pre-write state on the filling update
      wr(7, 1); wr(7, 1); wr(7, 1);
      q.push_back('{v: 1'b0, rd: 1'b0, md: 1'b1});
      op(1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b0);
      rd(7, 1, 1, 1);

      // Write to entry 6 concurrent with a read of entry 5
      q.push_back('{v: 1'b1, rd: 1'b1, md: 1'b1});
      op(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
      rd(6, 0, 0, 0);
      rd(5, 1, 1, 1);

      // Flush overrides same-cycle read and write
      wr(2, 1); wr(2, 1); wr(2, 1); wr(2, 1);
      op(1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b1);
      outs("flush", 3'b000);
      rd(2, 0, 0, 0);
      rd(5, 0, 0, 0);

      // Reset pulse mid-sequence on entry 9
      wr(4, 1); wr(4, 1); wr(4, 1); wr(4, 1);
      rd(4, 1, 1, 1);
      wr(9, 1); wr(9, 1);
      cpu_rstn = 1'b0;
      #2;
      outs("rst_pulse", 3'b000);
      cpu_rstn = 1'b1;
      wr(9, 1); wr(9, 0); wr(9, 1);
      rd(9, 0, 0, 0);
      wr(9, 1);
      rd(9, 1, 1, 1);
      rd(4, 0, 0, 0);

      repeat (2) op(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      check("drain", 8'(q.size()), 8'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
